// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that lets several byte producers share the UART TX FIFO write port.
// It holds each grant for a bounded burst and respects FIFO backpressure.
module uart_tx_arb #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic                       fifo_full,
  output logic                       fifo_wr_en,
  output logic [7:0]                 fifo_wr_data,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy
);

  localparam int unsigned GW = $clog2(NUM_REQ);
  localparam int unsigned CW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t                     state_q, state_d;
  logic   [GW-1:0]            grant_q, grant_d;
  logic   [GW-1:0]            last_q, last_d;
  logic   [CW-1:0]            cnt_q, cnt_d;
  logic   [GW-1:0]            pick;
  logic                       found;
  int unsigned                idx;
  logic   [NUM_REQ-1:0][7:0]  data_arr;
  logic                       wr;

  assign data_arr = req_data;
  assign grant_id = grant_q;
  assign busy     = (state_q == BURST);

  // First valid requester searching upward from the one after the last grant.
  always_comb begin
    pick  = last_q;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = 32'(last_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[GW'(idx)]) begin
        pick  = GW'(idx);
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and outputs; all write-side outputs stay low while rst is asserted.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = 8'h00;
    wr           = 1'b0;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = BURST;
        end
      end
      BURST: begin
        wr = req_valid[grant_q] && !fifo_full;
        if (!rst) begin
          req_ready[grant_q] = !fifo_full;
          fifo_wr_en         = wr;
          fifo_wr_data       = data_arr[grant_q];
        end
        if (wr && (cnt_q != CW'(MAX_BURST))) cnt_d = cnt_q + CW'(1);
        // A full-FIFO stall keeps the grant; only withdrawal, last byte or burst limit release.
        if (!req_valid[grant_q] ||
            (wr && (req_last[grant_q] || (cnt_q + CW'(1) == CW'(MAX_BURST))))) begin
          state_d = IDLE;
          last_d  = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
